serial_readout_mux: RTL

Parametrised successor to the fixed 8-channel serial output mux: a self-sequencing readout block that owns its own bit counter and frame state machine. After a `start` pulse it emits a frame on `serial_out`: header bits from the W/R serial path, then each enabled channel's serial data, then trailer bits from the W/R path. Per-channel shift enables advance only the selected channel serializer. It sits between the per-channel serializers and the chip's serial output pad, clocked by `sclk`.

---
 rtl/serial_readout_mux_pkg.sv | 61 ++++++
 rtl/serial_readout_mux_if.sv | 33 +++
 rtl/serial_readout_mux_ch_priority_enc.sv | 33 +++
 rtl/serial_readout_mux.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_readout_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_readout_pkg                                                   |
// | Shared types and helpers for serial_readout_mux: frame state enum,  |
// | default sizes, width helpers and the next-enabled-channel search.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package serial_readout_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    CH   = 2'd2,
    TRL  = 2'd3
  } readout_state_t;

  localparam int DEF_N_CH     = 8;
  localparam int DEF_CH_BITS  = 7;
  localparam int DEF_HDR_BITS = 4;
  localparam int DEF_TRL_BITS = 6;

  // Upper bound on channel count supported by the generic search function
  localparam int MAX_CH   = 64;
  localparam int CH_IDX_W = 6;

  typedef struct packed {
    logic                none;
    logic [CH_IDX_W-1:0] idx;
  } ch_sel_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set bit of mask at or above index 'from'; none=1 if there is none
  function automatic ch_sel_t next_enabled_ch(input logic [MAX_CH-1:0] mask,
                                              input int               from);
    ch_sel_t r;
    r.none = 1'b1;
    r.idx  = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) begin
        r.none = 1'b0;
        r.idx  = CH_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_readout_mux_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_readout_mux_if                                                |
// | Bundle of the readout mux request, per-channel data/shift and frame  |
// | status signals. master = frame requester/serializers, slave = mux.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface serial_readout_mux_if #(
  parameter int N_CH = serial_readout_pkg::DEF_N_CH
);
  localparam int CUR_W = serial_readout_pkg::idx_width(N_CH);

  logic             start;
  logic [N_CH-1:0]  ch_mask;
  logic [N_CH-1:0]  raw_serial_out;
  logic             wr_serial_out;
  logic             serial_out;
  logic [N_CH-1:0]  ch_shift;
  logic [CUR_W-1:0] cur_ch;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, ch_mask, raw_serial_out, wr_serial_out,
    input  serial_out, ch_shift, cur_ch, busy, frame_done
  );

  modport slave (
    input  start, ch_mask, raw_serial_out, wr_serial_out,
    output serial_out, ch_shift, cur_ch, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/serial_readout_mux_ch_priority_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ch_priority_enc                                                      |
// | Finds the next enabled channel: lowest set mask bit when 'first' is  |
// | high, otherwise the lowest set bit strictly above cur_ch.            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ch_priority_enc
  import serial_readout_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  localparam int CUR_W = idx_width(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [CUR_W-1:0] cur_ch,
  input  logic             first,
  output logic [CUR_W-1:0] next_ch,
  output logic             none
);

  ch_sel_t w_sel;
  int      w_from;

  // Search start point and result decode
  always_comb begin
    w_from  = first ? 0 : (int'(cur_ch) + 1);
    w_sel   = next_enabled_ch(MAX_CH'(mask), w_from);
    none    = w_sel.none || (int'(w_sel.idx) >= N_CH);
    next_ch = CUR_W'(w_sel.idx);
  end

endmodule
`default_nettype wire

// File: rtl/serial_readout_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_readout_mux                                                   |
// | Self-sequencing frame readout: header from the W/R path, each        |
// | enabled channel's serial data, then trailer from the W/R path.       |
// | Optional: SERIAL_READOUT_PARITY_EN appends an even-parity bit to     |
// | every channel slot.                                                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module serial_readout_mux
  import serial_readout_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int CH_BITS  = DEF_CH_BITS,
  parameter int HDR_BITS = DEF_HDR_BITS,
  parameter int TRL_BITS = DEF_TRL_BITS
) (
  input  logic                 sclk,
  input  logic                 rst,
  serial_readout_mux_if.slave  bus
);

  localparam int CUR_W = idx_width(N_CH);
  localparam int CNT_W = idx_width(max3(CH_BITS + 1, HDR_BITS, TRL_BITS));

`ifdef SERIAL_READOUT_PARITY_EN
  localparam int SLOT_BITS = CH_BITS + 1;
  localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(CH_BITS);
`else
  localparam int SLOT_BITS = CH_BITS;
`endif

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] TRL_LAST  = CNT_W'(TRL_BITS - 1);

  readout_state_t   state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [CUR_W-1:0] cur_ch_q, cur_ch_d;
  logic             serial_out_q, serial_out_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
`ifdef SERIAL_READOUT_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [N_CH-1:0]  w_enc_mask;
  logic [CUR_W-1:0] w_enc_next;
  logic             w_enc_none;
  logic [N_CH-1:0]  w_ch_shift;

  // In IDLE the incoming mask is searched so a header-less frame can jump
  // straight to its first channel; afterwards only the captured mask counts.
  assign w_enc_mask = (state_q == IDLE) ? bus.ch_mask : mask_q;

  ch_priority_enc #(.N_CH(N_CH)) u_enc (
    .mask    (w_enc_mask),
    .cur_ch  (cur_ch_q),
    .first   (state_q != CH),
    .next_ch (w_enc_next),
    .none    (w_enc_none)
  );

  // Frame sequencing, source selection and counters
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q + CNT_W'(1);
    mask_d       = mask_q;
    cur_ch_d     = cur_ch_q;
    serial_out_d = 1'b0;
    frame_done_d = 1'b0;
`ifdef SERIAL_READOUT_PARITY_EN
    parity_d     = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        cur_ch_d  = '0;
`ifdef SERIAL_READOUT_PARITY_EN
        parity_d  = 1'b0;
`endif
        if (bus.start) begin
          mask_d = bus.ch_mask;
          if (HDR_BITS > 0) begin
            state_d = HDR;
          end else if (w_enc_none) begin
            state_d = TRL;
          end else begin
            state_d  = CH;
            cur_ch_d = w_enc_next;
          end
        end
      end
      HDR: begin
        serial_out_d = bus.wr_serial_out;
        if (bit_cnt_q == HDR_LAST) begin
          bit_cnt_d = '0;
          if (w_enc_none) begin
            state_d = TRL;
          end else begin
            state_d  = CH;
            cur_ch_d = w_enc_next;
          end
        end
      end
      CH: begin
`ifdef SERIAL_READOUT_PARITY_EN
        if (bit_cnt_q == PAR_CNT) begin
          serial_out_d = parity_q;
        end else begin
          serial_out_d = bus.raw_serial_out[cur_ch_q];
          parity_d     = parity_q ^ bus.raw_serial_out[cur_ch_q];
        end
`else
        serial_out_d = bus.raw_serial_out[cur_ch_q];
`endif
        if (bit_cnt_q == SLOT_LAST) begin
          bit_cnt_d = '0;
`ifdef SERIAL_READOUT_PARITY_EN
          parity_d  = 1'b0;
`endif
          if (w_enc_none) begin
            state_d  = TRL;
            cur_ch_d = '0;
          end else begin
            cur_ch_d = w_enc_next;
          end
        end
      end
      TRL: begin
        serial_out_d = bus.wr_serial_out;
        if (bit_cnt_q == TRL_LAST) begin
          bit_cnt_d    = '0;
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Shift strobe for the channel sampled this cycle (never in a parity cycle)
  always_comb begin
    w_ch_shift = '0;
    if (state_q == CH) begin
`ifdef SERIAL_READOUT_PARITY_EN
      if (bit_cnt_q != PAR_CNT) w_ch_shift[cur_ch_q] = 1'b1;
`else
      w_ch_shift[cur_ch_q] = 1'b1;
`endif
    end
  end

  // State and registered outputs; reset aborts a frame without frame_done
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      mask_q       <= '0;
      cur_ch_q     <= '0;
      serial_out_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SERIAL_READOUT_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      mask_q       <= mask_d;
      cur_ch_q     <= cur_ch_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef SERIAL_READOUT_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.serial_out = serial_out_q;
  assign bus.ch_shift   = w_ch_shift;
  assign bus.cur_ch     = cur_ch_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire
